axis_flit_deserializer_rx: RTL and testbench

//  Receive end of the credit-based NoC flit link: sits after a router output port (or on the ejection port).

---
 rtl/noc_pkg.sv | 17 +
 rtl/noc_flit_fifo.sv | 46 ++++
 rtl/axis_flit_deserializer_rx.sv | 126 ++++++++++++
 tb/tb_axis_flit_deserializer_rx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared width helpers for the NoC receive path.
package noc_pkg;

    function automatic int flit_width(input int tdata_w, input int sf);
        return tdata_w / sf;
    endfunction

    function automatic int dest_width(input int tdest_w, input int tid_w);
        return tdest_w + tid_w;
    endfunction

    // Index width that stays at least 1 bit when the range has a single entry.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Receive flit FIFO: register array, async-reset pointers, full/empty flags.
module noc_flit_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = idx_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    // A write into a full FIFO is dropped so stored flits are never overwritten.
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/axis_flit_deserializer_rx.sv
// Credit-based NoC flit receiver packing SERIALIZATION_FACTOR flits per AXIS beat.
// Optional sticky protocol checker enabled by defining AXIS_DESER_RX_ERRCHK_EN.
module axis_flit_deserializer_rx
    import noc_pkg::*;
#(
    parameter int TDATA_WIDTH          = 128,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 4,
    parameter int SERIALIZATION_FACTOR = 1,
    parameter int FLIT_BUFFER_DEPTH    = 8,
    parameter int FLIT_WIDTH           = flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR),
    parameter int DEST_WIDTH           = dest_width(TDEST_WIDTH, TID_WIDTH)
) (
    input  logic                   clk_noc,
    input  logic                   rst_noc,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [TDATA_WIDTH-1:0] axis_out_tdata,
    output logic                   axis_out_tlast,
    output logic [TID_WIDTH-1:0]   axis_out_tid,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest,
    output logic                   rx_error
);
    localparam int SF  = SERIALIZATION_FACTOR;
    localparam int SIW = idx_w(SF);

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
    } flit_t;

    flit_t                  wr_flit;
    flit_t                  head;
    logic                   full;
    logic                   empty;
    logic                   pop;
    logic                   load;
    logic                   last_slot;
    logic                   out_free;
    logic [SIW-1:0]         slot_idx;
    logic [TDATA_WIDTH-1:0] asm_data;
    logic [DEST_WIDTH-1:0]  asm_dest;
    logic [TDATA_WIDTH-1:0] beat;
    logic [DEST_WIDTH-1:0]  beat_dest;

    assign wr_flit = {data_in, dest_in, is_tail_in};

    noc_flit_fifo #(
        .WIDTH($bits(flit_t)),
        .DEPTH(FLIT_BUFFER_DEPTH)
    ) u_fifo (
        .clk    (clk_noc),
        .rst    (rst_noc),
        .wr_en  (send_in),
        .wr_data(wr_flit),
        .rd_en  (pop),
        .rd_data(head),
        .full   (full),
        .empty  (empty)
    );

    // A beat-completing flit may only pop when the output register can take it,
    // so a stalled beat is never overwritten by an early tail.
    always_comb begin
        last_slot = (int'(slot_idx) == SF - 1);
        out_free  = !axis_out_tvalid || axis_out_tready;
        pop       = !empty && (out_free || (!last_slot && !head.is_tail));
        load      = pop && (last_slot || head.is_tail);
        beat      = asm_data;
        beat[int'(slot_idx)*FLIT_WIDTH +: FLIT_WIDTH] = head.data;
        beat_dest = (slot_idx == '0) ? head.dest : asm_dest;
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            slot_idx        <= '0;
            asm_data        <= '0;
            asm_dest        <= '0;
            axis_out_tvalid <= 1'b0;
            axis_out_tdata  <= '0;
            axis_out_tlast  <= 1'b0;
            axis_out_tid    <= '0;
            axis_out_tdest  <= '0;
            credit_out      <= 1'b0;
        end else begin
            credit_out <= pop;
            if (load) begin
                axis_out_tvalid <= 1'b1;
                axis_out_tdata  <= beat;
                axis_out_tlast  <= head.is_tail;
                axis_out_tid    <= beat_dest[DEST_WIDTH-1 -: TID_WIDTH];
                axis_out_tdest  <= beat_dest[TDEST_WIDTH-1:0];
                slot_idx        <= '0;
                asm_data        <= '0;
            end else begin
                if (axis_out_tvalid && axis_out_tready) axis_out_tvalid <= 1'b0;
                if (pop) begin
                    asm_data <= beat;
                    asm_dest <= beat_dest;
                    slot_idx <= slot_idx + SIW'(1);
                end
            end
        end
    end

`ifdef AXIS_DESER_RX_ERRCHK_EN
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            rx_error <= 1'b0;
        end else if ((send_in && full) || (pop && head.is_tail && !last_slot)) begin
            rx_error <= 1'b1;
        end
    end
`else
    logic unused_full;
    assign unused_full = full;
    assign rx_error    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_flit_deserializer_rx.sv
// Bench for axis_flit_deserializer_rx: SF=1 and SF=4 instances against a flit-to-beat queue model.
module tb_axis_flit_deserializer_rx;

`ifdef AXIS_DESER_RX_ERRCHK_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic clk, rst;
    // SF=1 instance (a_*) and SF=4 instance (b_*)
    logic [127:0] a_data, a_tdata, b_tdata;
    logic [31:0]  b_data;
    logic [5:0]   a_dest, b_dest;
    logic         a_tail, a_send, a_credit, a_tvalid, a_tready, a_tlast, a_err;
    logic         b_tail, b_send, b_credit, b_tvalid, b_tready, b_tlast, b_err;
    logic [1:0]   a_tid, b_tid;
    logic [3:0]   a_tdest, b_tdest;

    axis_flit_deserializer_rx dut_a (
        .clk_noc(clk), .rst_noc(rst), .data_in(a_data), .dest_in(a_dest),
        .is_tail_in(a_tail), .send_in(a_send), .credit_out(a_credit),
        .axis_out_tvalid(a_tvalid), .axis_out_tready(a_tready), .axis_out_tdata(a_tdata),
        .axis_out_tlast(a_tlast), .axis_out_tid(a_tid), .axis_out_tdest(a_tdest),
        .rx_error(a_err)
    );

    axis_flit_deserializer_rx #(.SERIALIZATION_FACTOR(4)) dut_b (
        .clk_noc(clk), .rst_noc(rst), .data_in(b_data), .dest_in(b_dest),
        .is_tail_in(b_tail), .send_in(b_send), .credit_out(b_credit),
        .axis_out_tvalid(b_tvalid), .axis_out_tready(b_tready), .axis_out_tdata(b_tdata),
        .axis_out_tlast(b_tlast), .axis_out_tid(b_tid), .axis_out_tdest(b_tdest),
        .rx_error(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [127:0] data;
        logic [5:0]   dest;
        logic         last;
    } beat_t;

    beat_t        q0[$], q1[$];
    logic [127:0] part_data[2];
    logic [5:0]   part_dest[2];
    int           part_k[2];
    int           credits[2];
    int           credit_cnt[2];
    bit           stall[2];
    logic [134:0] prev[2];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        for (int u = 0; u < 2; u++) begin
            part_data[u] = '0;
            part_dest[u] = '0;
            part_k[u]    = 0;
            credits[u]   = 8;
        end
    endtask

    // Flits accumulate into beats: slot k fills bits k*fw up; tail or a full beat closes it.
    task automatic model_flit(input int u, input logic [127:0] d, input logic [5:0] ds, input logic t);
        int    sf = (u == 0) ? 1 : 4;
        int    fw = (u == 0) ? 128 : 32;
        beat_t e;
        if (part_k[u] == 0) part_dest[u] = ds;
        part_data[u] = part_data[u] | (d << (part_k[u] * fw));
        part_k[u]++;
        if (t || part_k[u] == sf) begin
            e.data = part_data[u];
            e.dest = part_dest[u];
            e.last = t;
            if (u == 0) q0.push_back(e);
            else q1.push_back(e);
            part_k[u]    = 0;
            part_data[u] = '0;
        end
    endtask

    task automatic mon(input int u, input logic v, input logic r, input logic [134:0] o, input logic c);
        beat_t e;
        int    qs;
        if (stall[u]) chk("hold_stable", {v, o}, {1'b1, prev[u]});
        if (v && r) begin
            qs = (u == 0) ? q0.size() : q1.size();
            chk("beat_expected", qs != 0, 1'b1);
            if (qs != 0) begin
                if (u == 0) e = q0.pop_front();
                else e = q1.pop_front();
                chk(u == 0 ? "beat_a" : "beat_b", o, {e.last, e.dest, e.data});
            end
        end
        stall[u] = v && !r;
        prev[u]  = o;
        if (c) begin
            credits[u]++;
            credit_cnt[u]++;
            chk("credit_le_depth", credits[u] <= 8, 1'b1);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall[0] = 1'b0;
            stall[1] = 1'b0;
        end else begin
            mon(0, a_tvalid, a_tready, {a_tlast, a_tid, a_tdest, a_tdata}, a_credit);
            mon(1, b_tvalid, b_tready, {b_tlast, b_tid, b_tdest, b_tdata}, b_credit);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        a_send = 1'b0;
        b_send = 1'b0;
    endtask

    task automatic put_a(input logic [127:0] d, input logic [5:0] ds, input logic t, input bit m = 1'b1);
        a_send = 1'b1; a_data = d; a_dest = ds; a_tail = t;
        credits[0]--;
        if (m) model_flit(0, d, ds, t);
    endtask

    task automatic put_b(input logic [31:0] d, input logic [5:0] ds, input logic t);
        b_send = 1'b1; b_data = d; b_dest = ds; b_tail = t;
        credits[1]--;
        model_flit(1, {96'h0, d}, ds, t);
    endtask

    task automatic wait_vld(input int u, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(u == 0 ? a_tvalid : b_tvalid) && n < 50);
        chk(nm, (u == 0) ? a_tvalid : b_tvalid, 1'b1);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        tick();
        a_tready = 1'b1;
        b_tready = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk({nm, "_q0_empty"}, q0.size(), 0);
        chk({nm, "_q1_empty"}, q1.size(), 0);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        model_clear();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        a_send = 0; a_data = '0; a_dest = '0; a_tail = 0; a_tready = 1;
        b_send = 0; b_data = '0; b_dest = '0; b_tail = 0; b_tready = 1;
        credit_cnt[0] = 0;
        credit_cnt[1] = 0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_a", {a_tvalid, a_tlast, a_tid, a_tdest, a_tdata, a_credit, a_err}, '0);
        chk("reset_b", {b_tvalid, b_tlast, b_tid, b_tdest, b_tdata, b_credit, b_err}, '0);
        tick();
        rst = 1'b0;

        // single flit, SF=1: two-cycle latency to tvalid and credit
        tick();
        put_a({16{8'hA5}}, 6'h2B, 1'b1);
        tick();
        @(negedge clk);
        chk("t1_no_early_valid", a_tvalid, 1'b0);
        @(negedge clk);
        chk("t1_tvalid", a_tvalid, 1'b1);
        chk("t1_tid", a_tid, 2'b10);
        chk("t1_tdest", a_tdest, 4'hB);
        chk("t1_tlast", a_tlast, 1'b1);
        chk("t1_tdata", a_tdata, {16{8'hA5}});
        chk("t1_credit", a_credit, 1'b1);

        // SF=4 packing, slot 0 in LSBs, dest latched from first flit
        tick();
        put_b(32'h11, 6'h1C, 1'b0); tick();
        put_b(32'h22, 6'h3F, 1'b0); tick();
        put_b(32'h33, 6'h3F, 1'b0); tick();
        put_b(32'h44, 6'h3F, 1'b1); tick();
        wait_vld(1, "t2_valid");
        chk("t2_tdata", b_tdata, 128'h00000044_00000033_00000022_00000011);
        chk("t2_tlast", b_tlast, 1'b1);
        chk("t2_tid_tdest", {b_tid, b_tdest}, 6'h1C);

        // stalled output: one beat held, one credit, then eight beats in order
        tick();
        a_tready = 1'b0;
        base = credit_cnt[0];
        for (int i = 0; i < 8; i++) begin
            put_a({96'h0, 32'hC0DE0000 + i}, 6'(i), 1'(i % 2));
            tick();
        end
        repeat (10) @(negedge clk);
        chk("t3_held_valid", a_tvalid, 1'b1);
        chk("t3_held_data", a_tdata, {96'h0, 32'hC0DE0000});
        chk("t3_one_credit", credit_cnt[0] - base, 1);
        tick();
        a_tready = 1'b1;
        repeat (15) tick();
        chk("t3_eight_credits", credit_cnt[0] - base, 8);
        chk("t3_all_beats", q0.size(), 0);

        // overflow: tenth back-to-back flit meets a full FIFO and is dropped
        tick();
        a_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            put_a({96'h0, 32'hF0000 + i}, 6'h05, 1'b1, i < 9);
            tick();
        end
        repeat (3) @(negedge clk);
        chk("ovf_rx_error", a_err, ERR);
        drain("ovf");
        do_reset();
        @(negedge clk);
        chk("ovf_err_cleared", a_err, 1'b0);

        // early tail on second flit
        tick();
        put_b(32'hAAAA0001, 6'h25, 1'b0); tick();
        put_b(32'hBBBB0002, 6'h25, 1'b1); tick();
        wait_vld(1, "t4_valid");
        chk("t4_tdata", b_tdata, {64'h0, 32'hBBBB0002, 32'hAAAA0001});
        chk("t4_tlast", b_tlast, 1'b1);
        chk("t4_tid_tdest", {b_tid, b_tdest}, 6'h25);
        repeat (2) @(negedge clk);
        chk("t4_rx_error", b_err, ERR);

        // async reset mid-beat with a stalled beat pending
        tick();
        b_tready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            put_b(32'(i), 6'h11, i == 4);
            tick();
        end
        repeat (4) @(negedge clk);
        chk("t6_pre_valid", b_tvalid, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_clear", {b_tvalid, b_tlast, b_tid, b_tdest, b_tdata, b_credit, b_err}, '0);
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        tick();
        b_tready = 1'b1;
        for (int i = 7; i <= 10; i++) begin
            put_b(32'(i), 6'h32, i == 10);
            tick();
        end
        wait_vld(1, "t6_valid");
        chk("t6_tdata", b_tdata, 128'h0000000A_00000009_00000008_00000007);
        chk("t6_tid_tdest", {b_tid, b_tdest}, 6'h32);

        // randomized traffic under credit control
        for (int c = 0; c < 13000; c++) begin
            tick();
            a_tready = ($urandom % 4) != 0;
            b_tready = ($urandom % 4) != 0;
            if (credits[0] > 0 && ($urandom % 5) != 0)
                put_a({$urandom, $urandom, $urandom, $urandom}, 6'($urandom), ($urandom % 4) == 0);
            if (credits[1] > 0 && ($urandom % 5) != 0)
                put_b($urandom, 6'($urandom), ($urandom % 6) == 0);
        end
        tick();
        b_tready = 1'b1;
        for (int n = 0; n < 50 && credits[1] <= 0; n++) tick();
        if (part_k[1] != 0) begin
            put_b(32'h7A11, 6'h00, 1'b1);
            tick();
        end
        drain("rand");
        chk("rand_credits_a", credits[0], 8);
        chk("rand_credits_b", credits[1], 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
